// File: rtl/udp_word_rx_pkg.sv
// Shared types and constants for the UDP word receiver.
// The receive FSM state encoding and the default command port live here.
package udp_rx_pkg;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_BODY  = 2'd1,
        S_SKIP  = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_CMD_PORT = 16'h1000;

endpackage

// File: rtl/udp_word_rx_commit_fifo.sv
// Word FIFO with a speculative write pointer: frame words are written ahead of
// wr_commit and become readable only on commit, or are discarded on rollback.
module commit_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          commit,
    input  logic          rollback,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          spec_full,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic          do_wr;
    logic          do_rd;

    // Space is judged against rd_ptr as it stands; a pop in the same cycle is not credited.
    assign spec_full = (wr_spec_q - rd_ptr_q) == PW'(DEPTH);
    assign level     = wr_commit_q - rd_ptr_q;
    assign full      = level == PW'(DEPTH);
    assign empty     = level == '0;
    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr       = wr_en && !spec_full && !rollback;
        do_rd       = rd_en && !empty;
        rd_ptr_d    = rd_ptr_q + PW'(do_rd);
        wr_spec_d   = rollback ? wr_commit_q : wr_spec_q + PW'(do_wr);
        wr_commit_d = commit ? wr_spec_q + PW'(do_wr) : wr_commit_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_spec_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/udp_word_rx.sv
// Packs UDP payload bytes for one destination port into big-endian words and
// hands whole good frames to a commit FIFO; bad or oversized frames roll back.
module udp_word_rx
    import udp_rx_pkg::*;
#(
    parameter logic [15:0] PORT       = DEFAULT_CMD_PORT,
    parameter int          WORD_BYTES = 4,
    parameter int          DEPTH      = 16,
    parameter int          STRICT_LEN = 1,
    parameter int          CNT_W      = 16,
    localparam int         W          = 8 * WORD_BYTES,
    localparam int         LW         = $clog2(DEPTH) + 1,
    localparam int         IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      dest_port,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    input  logic             rd_en,
    output logic [W-1:0]     data,
    output logic             data_ready,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output state_t           dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     word_q, word_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             take;
    logic             finish;
    logic [W-1:0]     cur_word;
    logic             word_complete;
    logic             partial;
    logic             wr_req;
    logic             ovf_now;
    logic             bad;
    logic             good;
    logic             spec_full;

    // Handshake: a beat is s_axis_tvalid high at a rising edge; there is no
    // back-pressure, every beat is consumed in the cycle it is presented.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FIRST: if (s_axis_tvalid) begin
                if (dest_port != PORT) state_d = s_axis_tlast ? S_FIRST : S_SKIP;
                else                   state_d = s_axis_tlast ? S_FIRST : S_BODY;
            end
            S_BODY:  if (s_axis_tvalid && s_axis_tlast) state_d = S_FIRST;
            S_SKIP:  if (s_axis_tvalid && s_axis_tlast) state_d = S_FIRST;
            default: state_d = S_FIRST;
        endcase
    end

    always_comb begin
        take   = s_axis_tvalid &&
                 ((state_q == S_FIRST && dest_port == PORT) || state_q == S_BODY);
        finish = take && s_axis_tlast;
    end

    assign dbg_state = state_q;

    // Byte k of a word occupies the k-th most significant byte lane.
    always_comb begin
        cur_word = word_q;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) cur_word[8*(WORD_BYTES-1-k) +: 8] = s_axis_tdata;
        end
    end

    always_comb begin
        word_complete = take && (idx_q == LAST_IDX);
        partial       = finish && !word_complete;
        wr_req        = word_complete || (partial && (STRICT_LEN == 0));
        ovf_now       = wr_req && spec_full;
        bad           = finish && (s_axis_tuser || ovf_q || ovf_now ||
                                   ((STRICT_LEN != 0) && partial));
        good          = finish && !bad;
    end

    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (take) begin
            if (word_complete || finish) begin
                word_d = '0;
                idx_d  = '0;
            end else begin
                word_d = cur_word;
                idx_d  = idx_q + IDX_W'(1);
            end
            ovf_d = finish ? 1'b0 : (ovf_q | ovf_now);
        end
        if (good) frame_cnt_d = frame_cnt_q + CNT_W'(1);
        if (bad && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            word_q      <= word_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    commit_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_req && !bad),
        .wr_data   (cur_word),
        .commit    (good),
        .rollback  (bad),
        .rd_en     (rd_en),
        .rd_data   (data),
        .spec_full (spec_full),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign data_ready = !empty;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
